// File: rtl/sw_affine_pe_maxtrack.sv
// rtl/sw_affine_pe_maxtrack.sv - Smith-Waterman affine-gap systolic PE; best-score tracking enabled by SW_PE_MAXTRACK_EN
`timescale 1ns/1ps
module sw_affine_pe_maxtrack #(
  parameter int SCORE_W  = 10,
  parameter int SYM_W    = 2,
  parameter int COL_W    = 12,
  parameter int MATCH    = 10,
  parameter int MISMATCH = -2,
  parameter int GAP_OPEN = 2,
  parameter int GAP_EXT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [SCORE_W-1:0] V_in,
  input  logic [SCORE_W-1:0] F_in,
  input  logic [SYM_W-1:0]   T_in,
  input  logic [SYM_W-1:0]   S_in,
  input  logic               store_S_in,
  input  logic               init_in,
  input  logic [SCORE_W-1:0] init_V,
  input  logic [SCORE_W-1:0] init_E,
  output logic [SCORE_W-1:0] V_out,
  output logic [SCORE_W-1:0] E_out,
  output logic [SCORE_W-1:0] F_out,
  output logic [SYM_W-1:0]   S_out,
  output logic [SYM_W-1:0]   T_out,
  output logic               store_S_out,
  output logic               init_out,
  output logic [SCORE_W-1:0] max_score,
  output logic [COL_W-1:0]   max_col
);

  // Two guard bits keep every intermediate sum exact before saturation.
  localparam int WW = SCORE_W + 2;
  typedef logic signed [WW-1:0] wide_t;

  localparam wide_t SAT_HI     = wide_t'((2 ** (SCORE_W - 1)) - 1);
  localparam wide_t SAT_LO     = wide_t'(-(2 ** (SCORE_W - 1)));
  localparam wide_t MATCH_W    = wide_t'(MATCH);
  localparam wide_t MISMATCH_W = wide_t'(MISMATCH);
  localparam wide_t GO_W       = wide_t'(GAP_OPEN);
  localparam wide_t GE_W       = wide_t'(GAP_EXT);

  function automatic wide_t sext(input logic [SCORE_W-1:0] x);
    return wide_t'($signed(x));
  endfunction

  function automatic wide_t wmax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [SCORE_W-1:0] sat(input wide_t x);
    if (x > SAT_HI) return SAT_HI[SCORE_W-1:0];
    else if (x < SAT_LO) return SAT_LO[SCORE_W-1:0];
    else return x[SCORE_W-1:0];
  endfunction

  logic [SCORE_W-1:0] v_q, v_d, e_q, e_d, f_q, f_d, vdiag_q, vdiag_d;
  logic [SYM_W-1:0]   s_q, s_d, t_q, t_d;
  logic               store_q, store_d, init_q, init_d;

  wide_t              fn_w, en_w, diag_w, hn_w;
  logic [SCORE_W-1:0] fn, en, hn;
  logic               compute;

  assign compute = init_in & ~store_S_in;

  // Affine-gap recurrence: F from upstream, E from own previous cell, H = max of all with floor 0.
  always_comb begin
    fn_w   = wmax(sext(V_in) - GO_W, sext(F_in) - GE_W);
    en_w   = wmax(sext(v_q) - GO_W, sext(e_q) - GE_W);
    diag_w = sext(vdiag_q) + ((s_q == T_in) ? MATCH_W : MISMATCH_W);
    hn_w   = wmax(wmax('0, diag_w), wmax(en_w, fn_w));
    fn     = sat(fn_w);
    en     = sat(en_w);
    hn     = sat(hn_w);
  end

  // Next-state selection: init loads seeds, compute advances the cell, store-only holds scores.
  always_comb begin
    v_d     = v_q;
    e_d     = e_q;
    f_d     = f_q;
    vdiag_d = vdiag_q;
    s_d     = store_S_in ? S_in : s_q;
    t_d     = T_in;
    store_d = store_S_in;
    init_d  = init_in;
    if (!init_in) begin
      v_d     = init_V;
      e_d     = init_E;
      vdiag_d = init_V;
    end else if (compute) begin
      v_d     = hn;
      e_d     = en;
      f_d     = fn;
      vdiag_d = V_in;
    end
  end

  // Pipeline registers; stall freezes everything including pass-throughs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      vdiag_q <= '0;
      s_q     <= '0;
      t_q     <= '0;
      store_q <= 1'b0;
      init_q  <= 1'b0;
    end else if (!stall) begin
      v_q     <= v_d;
      e_q     <= e_d;
      f_q     <= f_d;
      vdiag_q <= vdiag_d;
      s_q     <= s_d;
      t_q     <= t_d;
      store_q <= store_d;
      init_q  <= init_d;
    end
  end

  assign V_out       = v_q;
  assign E_out       = e_q;
  assign F_out       = f_q;
  assign S_out       = s_q;
  assign T_out       = t_q;
  assign store_S_out = store_q;
  assign init_out    = init_q;

`ifdef SW_PE_MAXTRACK_EN
  logic [COL_W-1:0]   col_q, col_d, max_col_q, max_col_d;
  logic [SCORE_W-1:0] max_q, max_d;

  // Column counter saturates; strict compare keeps the earliest column on ties.
  always_comb begin
    col_d     = col_q;
    max_d     = max_q;
    max_col_d = max_col_q;
    if (!init_in) begin
      col_d     = '0;
      max_d     = '0;
      max_col_d = '0;
    end else if (compute) begin
      col_d = (col_q == '1) ? col_q : col_q + COL_W'(1);
      if ($signed(hn) > $signed(max_q)) begin
        max_d     = hn;
        max_col_d = col_q;
      end
    end
  end

  // Best-score tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      max_q     <= '0;
      max_col_q <= '0;
    end else if (!stall) begin
      col_q     <= col_d;
      max_q     <= max_d;
      max_col_q <= max_col_d;
    end
  end

  assign max_score = max_q;
  assign max_col   = max_col_q;
`else
  assign max_score = '0;
  assign max_col   = '0;
`endif

endmodule

// File: tb/tb_sw_affine_pe_maxtrack.sv
// tb/tb_sw_affine_pe_maxtrack.sv - self-checking bench for sw_affine_pe_maxtrack
`timescale 1ns/1ps
module tb_sw_affine_pe_maxtrack;
  localparam int SW = 10, YW = 2, CW = 12;
  localparam int MATCH = 10, MISMATCH = -2, GO = 2, GE = 1;

  logic clk = 0, rst = 0, stall = 0;
  logic [SW-1:0] V_in = 0, F_in = 0, init_V = 0, init_E = 0;
  logic [YW-1:0] T_in = 0, S_in = 0;
  logic store_S_in = 0, init_in = 1;
  logic [SW-1:0] V_out, E_out, F_out, max_score;
  logic [YW-1:0] S_out, T_out;
  logic store_S_out, init_out;
  logic [CW-1:0] max_col;

  logic stall6 = 0;
  logic [5:0] V_in6 = 0, F_in6 = 0, init_V6 = 0, init_E6 = 0;
  logic [YW-1:0] T_in6 = 0, S_in6 = 0;
  logic store6 = 0, init6 = 1;
  logic [5:0] V_out6, E_out6, F_out6, max_score6;
  logic [YW-1:0] S_out6, T_out6;
  logic store_out6, init_out6;
  logic [CW-1:0] max_col6;

  sw_affine_pe_maxtrack dut (
    .clk(clk), .rst(rst), .stall(stall), .V_in(V_in), .F_in(F_in), .T_in(T_in), .S_in(S_in),
    .store_S_in(store_S_in), .init_in(init_in), .init_V(init_V), .init_E(init_E),
    .V_out(V_out), .E_out(E_out), .F_out(F_out), .S_out(S_out), .T_out(T_out),
    .store_S_out(store_S_out), .init_out(init_out), .max_score(max_score), .max_col(max_col));

  sw_affine_pe_maxtrack #(.SCORE_W(6)) dut6 (
    .clk(clk), .rst(rst), .stall(stall6), .V_in(V_in6), .F_in(F_in6), .T_in(T_in6), .S_in(S_in6),
    .store_S_in(store6), .init_in(init6), .init_V(init_V6), .init_E(init_E6),
    .V_out(V_out6), .E_out(E_out6), .F_out(F_out6), .S_out(S_out6), .T_out(T_out6),
    .store_S_out(store_out6), .init_out(init_out6), .max_score(max_score6), .max_col(max_col6));

  always #5 clk = ~clk;

  logic [57:0] act;
  logic [41:0] act6;
  assign act  = {V_out, E_out, F_out, S_out, T_out, store_S_out, init_out, max_score, max_col};
  assign act6 = {V_out6, E_out6, F_out6, S_out6, T_out6, store_out6, init_out6, max_score6, max_col6};

  int vectors = 0, miscompares = 0;
  int mv, me, mf, mdiag, ms, mt, mst, mi, mcol, mmax, mmaxcol;

  logic [1:0] tstream [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
  int exp_v [3][8] = '{'{10, 8, 10, 8, 10, 8, 7, 10},
                       '{0, 10, 8, 7, 6, 10, 8, 7},
                       '{8, 8, 8, 8, 8, 8, 20, 18}};
  int exp_f [3]    = '{-1, -1, 8};
  int sc_sym [3]   = '{0, 1, 3};
  int sc_vin [3]   = '{0, 0, 10};
  int sc_fin [3]   = '{0, 0, -4};
  int sc_max [3]   = '{10, 10, 20};
  int sc_col [3]   = '{0, 1, 6};

  function automatic int clamp(input int x, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [57:0] exp_vec();
    int xmax, xcol;
    xmax = 0;
    xcol = 0;
`ifdef SW_PE_MAXTRACK_EN
    xmax = mmax;
    xcol = mmaxcol;
`endif
    return {SW'(mv), SW'(me), SW'(mf), YW'(ms), YW'(mt), 1'(mst), 1'(mi), SW'(xmax), CW'(xcol)};
  endfunction

  task automatic model_reset();
    mv = 0; me = 0; mf = 0; mdiag = 0; ms = 0; mt = 0; mst = 0; mi = 0;
    mcol = 0; mmax = 0; mmaxcol = 0;
  endtask

  // Advance one clock and apply the cell rules to the model using the inputs seen at that edge.
  task automatic tick();
    int fnr, enr, hnr, sub;
    @(posedge clk);
    if (!rst && !stall) begin
      if (!init_in) begin
        mv = $signed(init_V); me = $signed(init_E); mdiag = mv;
        mcol = 0; mmax = 0; mmaxcol = 0;
      end else if (!store_S_in) begin
        fnr = imax($signed(V_in) - GO, $signed(F_in) - GE);
        enr = imax(mv - GO, me - GE);
        sub = (ms == int'(T_in)) ? MATCH : MISMATCH;
        hnr = imax(imax(0, mdiag + sub), imax(enr, fnr));
        mv = clamp(hnr, SW); me = clamp(enr, SW); mf = clamp(fnr, SW);
        mdiag = $signed(V_in);
        if (mv > mmax) begin mmax = mv; mmaxcol = mcol; end
        if (mcol < (1 << CW) - 1) mcol++;
      end
      if (store_S_in) ms = int'(S_in);
      mt = int'(T_in); mst = int'(store_S_in); mi = int'(init_in);
    end
    #1;
  endtask

  task automatic drive(input logic ini, input logic sto, input logic [1:0] s, input logic [1:0] t,
                       input logic [SW-1:0] vi, input logic [SW-1:0] fi);
    init_in = ini; store_S_in = sto; S_in = s; T_in = t; V_in = vi; F_in = fi;
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst = 1;
    #2;
    vectors++;
    if (act !== 58'd0) begin miscompares++; $display("FAIL reset_main act=%h exp=0", act); end
    vectors++;
    if (act6 !== 42'd0) begin miscompares++; $display("FAIL reset_w6 act=%h exp=0", act6); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_scenarios();
    for (int sc = 0; sc < 3; sc++) begin
      init_V = 0; init_E = 0;
      drive(1'b1, 1'b1, 2'(sc_sym[sc]), 2'd0, SW'(sc_vin[sc]), SW'(sc_fin[sc])); tick();
      drive(1'b0, 1'b0, 2'(sc_sym[sc]), 2'd0, SW'(sc_vin[sc]), SW'(sc_fin[sc])); tick();
      vectors++;
      if (act !== exp_vec()) begin miscompares++; $display("FAIL sc%0d_init act=%h exp=%h", sc, act, exp_vec()); end
      for (int k = 0; k < 8; k++) begin
        drive(1'b1, 1'b0, 2'(sc_sym[sc]), tstream[k], SW'(sc_vin[sc]), SW'(sc_fin[sc])); tick();
        vectors++;
        if (act !== exp_vec()) begin miscompares++; $display("FAIL sc%0d_model[%0d] act=%h exp=%h", sc, k, act, exp_vec()); end
        vectors++;
        if (V_out !== SW'(exp_v[sc][k])) begin miscompares++; $display("FAIL sc%0d_V[%0d] act=%0d exp=%0d", sc, k, $signed(V_out), exp_v[sc][k]); end
        vectors++;
        if (F_out !== SW'(exp_f[sc])) begin miscompares++; $display("FAIL sc%0d_F[%0d] act=%0d exp=%0d", sc, k, $signed(F_out), exp_f[sc]); end
        vectors++;
        if (T_out !== tstream[k]) begin miscompares++; $display("FAIL sc%0d_T[%0d] act=%0d exp=%0d", sc, k, T_out, tstream[k]); end
      end
`ifdef SW_PE_MAXTRACK_EN
      vectors++;
      if (max_score !== SW'(sc_max[sc]) || max_col !== CW'(sc_col[sc])) begin
        miscompares++; $display("FAIL sc%0d_max act=%0d@%0d exp=%0d@%0d", sc, max_score, max_col, sc_max[sc], sc_col[sc]);
      end
`else
      vectors++;
      if (max_score !== '0 || max_col !== '0) begin
        miscompares++; $display("FAIL sc%0d_max_tied act=%0d@%0d exp=0@0", sc, max_score, max_col);
      end
`endif
    end
  endtask

  task automatic test_stall();
    init_V = 0; init_E = 0;
    drive(1'b1, 1'b1, 2'd0, 2'd0, '0, '0); tick();
    drive(1'b0, 1'b0, 2'd0, 2'd0, '0, '0); tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 2'd0, tstream[k], '0, '0); tick();
      vectors++;
      if (V_out !== SW'(exp_v[0][k]) || act !== exp_vec()) begin
        miscompares++; $display("FAIL stall_seq[%0d] act=%h exp=%h", k, act, exp_vec());
      end
      if (k == 3) begin
        for (int j = 0; j < 3; j++) begin
          stall = 1;
          drive(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), SW'($urandom), SW'($urandom));
          init_V = SW'($urandom);
          tick();
          vectors++;
          if (act !== exp_vec() || V_out !== SW'(exp_v[0][3])) begin
            miscompares++; $display("FAIL stall_frozen[%0d] act=%h exp=%h", j, act, exp_vec());
          end
        end
        stall = 0; init_V = 0;
      end
    end
  endtask

  task automatic test_saturation_w6();
    stall6 = 0; init_V6 = 0; init_E6 = 0; S_in6 = 0; T_in6 = 0; V_in6 = 6'd31; F_in6 = 0;
    init6 = 1; store6 = 1; tick();
    init6 = 0; store6 = 0; tick();
    for (int k = 0; k < 6; k++) begin
      init6 = 1; tick();
      vectors++;
      if (V_out6 !== ((k == 0) ? 6'd29 : 6'd31)) begin
        miscompares++; $display("FAIL sat_w6_V[%0d] act=%0d exp=%0d", k, $signed(V_out6), (k == 0) ? 29 : 31);
      end
    end
`ifdef SW_PE_MAXTRACK_EN
    vectors++;
    if (max_score6 !== 6'd31 || max_col6 !== CW'(1)) begin
      miscompares++; $display("FAIL sat_w6_max act=%0d@%0d exp=31@1", max_score6, max_col6);
    end
`endif
    init6 = 0;
  endtask

  task automatic test_async_reset();
    init_V = 0; init_E = 0;
    drive(1'b1, 1'b1, 2'd0, 2'd0, '0, '0); tick();
    drive(1'b0, 1'b0, 2'd0, 2'd0, '0, '0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 2'd0, tstream[k], '0, '0); tick();
    end
    #2 rst = 1;
    #1;
    model_reset();
    vectors++;
    if (act !== 58'd0) begin miscompares++; $display("FAIL async_rst_immediate act=%h exp=0", act); end
    @(posedge clk); #1;
    vectors++;
    if (act !== 58'd0) begin miscompares++; $display("FAIL async_rst_held act=%h exp=0", act); end
    rst = 0;
    drive(1'b0, 1'b0, 2'd0, 2'd0, '0, '0); tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 2'd0, tstream[k], '0, '0); tick();
      vectors++;
      if (V_out !== SW'(exp_v[0][k]) || act !== exp_vec()) begin
        miscompares++; $display("FAIL post_rst_seq[%0d] act=%h exp=%h", k, act, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      stall = (r < 10);
      drive((r >= 10 && r < 18) ? 1'b0 : 1'b1, (r >= 18 && r < 26), 2'($urandom), 2'($urandom),
            SW'($urandom), SW'($urandom));
      init_V = SW'($urandom); init_E = SW'($urandom);
      tick();
      vectors++;
      if (act !== exp_vec()) begin miscompares++; $display("FAIL random[%0d] act=%h exp=%h", i, act, exp_vec()); end
    end
    stall = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scenarios();
    test_stall();
    test_saturation_w6();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sw_affine_pe_maxtrack.md
Name: sw_affine_pe_maxtrack

Overview:
- Parametrised next-generation Smith-Waterman systolic-array PE with affine gap penalty.
- Generalises score width, symbol width (DNA or protein alphabets) and scoring constants.
- Adds saturating arithmetic, a stall-safe pipeline and per-PE tracking of the best local score and the column where it occurred.
- One PE holds one short-read symbol; reference symbols and scores stream through a chain of PEs.

Parameters:
SCORE_W, 10, width of V/E/F/max_score (two's complement)
SYM_W, 2, symbol width (2 = DNA, 5 = protein)
COL_W, 12, width of column counter / max_col
MATCH, 10, substitution score when S == T (signed)
MISMATCH, -2, substitution score when S != T (signed)
GAP_OPEN, 2, gap-open penalty magnitude (positive)
GAP_EXT, 1, gap-extend penalty magnitude (positive)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall  in  1  freeze all state and outputs
V_in  in  SCORE_W  H from upstream PE (signed)
F_in  in  SCORE_W  F from upstream PE (signed)
T_in  in  SYM_W  reference symbol
S_in  in  SYM_W  short-read symbol to load/forward
store_S_in  in  1  load S_in into this PE
init_in  in  1  0 = initialise, 1 = compute
init_V  in  SCORE_W  initial H / diagonal value
init_E  in  SCORE_W  initial E value
V_out  out  SCORE_W  registered H
E_out  out  SCORE_W  registered E
F_out  out  SCORE_W  registered F
S_out  out  SYM_W  stored symbol
T_out  out  SYM_W  T_in delayed 1 cycle
store_S_out  out  1  store_S_in delayed 1 cycle
init_out  out  1  init_in delayed 1 cycle
max_score  out  SCORE_W  best H since last init
max_col  out  COL_W  column index of max_score

Behaviour:
- Reset: every output, S_reg, Vdiag and col are 0. Reset is asynchronous and overrides everything, including mid-stream; streaming restarts only after an init cycle.
- stall=1: no register changes, including pass-throughs.
- Otherwise, every cycle:
  - T_out<=T_in, store_S_out<=store_S_in, init_out<=init_in.
  - S_out<=S_in when store_S_in=1.
- Cycle type when not stalled:
  - Init cycle (init_in=0): V_out<=init_V, E_out<=init_E, Vdiag<=init_V, col<=0, max_score<=0, max_col<=0. F_out holds. Applies regardless of store_S_in.
  - Compute cycle (init_in=1, store_S_in=0):
    - Fn=max(V_in-GAP_OPEN, F_in-GAP_EXT)
    - En=max(V_out-GAP_OPEN, E_out-GAP_EXT)
    - sub = (S_out==T_in) ? MATCH : MISMATCH
    - Hn=max(0, Vdiag+sub, En, Fn)
    - V_out<=Hn, E_out<=En, F_out<=Fn, Vdiag<=V_in.
    - col<=col+1, saturating at all-ones.
  - store_S_in=1 with init_in=1: score registers, col and max hold.
- Latency: 1 cycle for every output.
- Arithmetic: signed, computed at SCORE_W+2 bits, then saturated to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1]. Hn floors at 0.
- Max tracking, on compute cycles:
  - If Hn > max_score: max_score<=Hn, max_col<=col (value before increment).
  - Ties keep the earliest column.

Optional Feature:
- SW_PE_MAXTRACK_EN.
- Defined: max_score/max_col behave as above.
- Undefined: the tracking logic is removed and max_score/max_col are tied to 0. col still exists only if needed. All other behaviour is identical.

Test Plan:
- Defaults, V_in=0, F_in=0, init_V=init_E=0. Store S=A, one init cycle, then compute T=A,C,A,G,A,C,T,A. Required:
  - V_out = 10,8,10,8,10,8,7,10
  - F_out = -1 every cycle
  - T_out echoes T with 1-cycle delay
  - max_score=10, max_col=0
- Store S=C, then the same stream. Required: V_out = 0,10,8,7,6,10,8,7; max_score=10, max_col=1.
- Store S=T, V_in=10, F_in=-4, then the same stream. Required:
  - F_out=8 every cycle
  - V_out = 8,8,8,8,8,8,20,18
  - max_score=20, max_col=6
- Assert stall for 3 cycles mid-stream in the first scenario. All outputs frozen, then the sequence resumes unchanged with 3-cycle offset.
- SCORE_W=6, matching stream with V_in=31. V_out saturates at 31, with no wrap to negative.
- Assert rst for 1 cycle mid-stream. All outputs 0 immediately (asynchronous). After an init cycle, the first scenario's values repeat.
